// File: rtl/radar_pkg.sv
// Shared types and default timing for the radar pulse-compression chain.
// Used by the pulse sequencer, the chirp generator and the FIR capture logic.
package radar_pkg;

   // Width of every frame/window counter in the chain.
   localparam int unsigned CNT_W = 16;

   // Default timing at 100 MHz: 50 us frame, 256-cycle chirp, 512-cycle receive window.
   localparam int unsigned DefPriCycles   = 5000;
   localparam int unsigned DefChirpLen    = 256;
   localparam int unsigned DefGuardCycles = 16;
   localparam int unsigned DefRxLen       = 512;

   // Sequencer states for one pulse repetition interval.
   typedef enum logic [2:0] {
      StIdle,
      StTx,
      StGuard,
      StRx,
      StDump,
      StWait
   } seq_state_e;

endpackage

// File: rtl/radar_pulse_seq_pri_timer.sv
// Saturating frame (PRI) counter with synchronous clear.
// pri_last_o flags the final cycle of the frame; the count holds there until cleared.
module pri_timer #(
   parameter int unsigned PRI_CYCLES = radar_pkg::DefPriCycles,
   parameter int unsigned CNT_W      = radar_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] pri_cnt_o,
   output logic             pri_last_o
);
   import radar_pkg::*;

   localparam logic [CNT_W-1:0] PriLast = CNT_W'(PRI_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up and stop at the last frame cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != PriLast)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pri_cnt_o  = cnt_q;
   assign pri_last_o = (cnt_q == PriLast);

endmodule

// File: rtl/radar_pulse_seq.sv
// Radar frame sequencer: transmit window, guard gap, receive window, result dump, then wait
// out the rest of the PRI. All outputs are registered decodes of the next state.
// Build option: define RADAR_PULSE_SEQ_DUMP_EN to enable the DUMP state, dump_req/dump_ack
// handshake and sticky overrun flag; without it RX goes straight to WAIT.
module radar_pulse_seq #(
   parameter int unsigned PRI_CYCLES   = radar_pkg::DefPriCycles,
   parameter int unsigned CHIRP_LEN    = radar_pkg::DefChirpLen,
   parameter int unsigned GUARD_CYCLES = radar_pkg::DefGuardCycles,
   parameter int unsigned RX_LEN       = radar_pkg::DefRxLen,
   parameter int unsigned CNT_W        = radar_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             dump_ack,
   output logic             chirp_start,
   output logic             chirp_en,
   output logic             dac_pd,
   output logic             fir_clear,
   output logic             fir_en,
   output logic             dump_req,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] pulse_cnt
);
   import radar_pkg::*;

   // The whole TX/GUARD/RX sequence plus one decision cycle must fit inside a frame.
   if (PRI_CYCLES < CHIRP_LEN + GUARD_CYCLES + RX_LEN + 2) begin : g_bad_timing
      $fatal(1, "radar_pulse_seq: PRI_CYCLES too short for CHIRP_LEN+GUARD_CYCLES+RX_LEN+2");
   end

   localparam logic [CNT_W-1:0] ChirpLast = CNT_W'(CHIRP_LEN - 1);
   localparam logic [CNT_W-1:0] GuardLast = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RxLast    = CNT_W'(RX_LEN - 1);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic             chirp_start_q, chirp_start_d;
   logic             chirp_en_q, chirp_en_d;
   logic             dac_pd_q, dac_pd_d;
   logic             fir_clear_q, fir_clear_d;
   logic             fir_en_q, fir_en_d;
   logic             busy_q, busy_d;
   logic             frame_start;
   logic [CNT_W-1:0] pri_cnt;
   logic             pri_last;

   pri_timer #(
      .PRI_CYCLES (PRI_CYCLES),
      .CNT_W      (CNT_W)
   ) u_pri_timer (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (frame_start),
      .en_i       (state_q != StIdle),
      .pri_cnt_o  (pri_cnt),
      .pri_last_o (pri_last)
   );

   // Next state, window counter and next output values.
   always_comb begin
      state_d = state_q;
      win_d   = win_q + 1'b1;
      unique case (state_q)
         StIdle: begin
            win_d = '0;
            if (run) state_d = StTx;
         end
         StTx: begin
            if (win_q == ChirpLast) begin
               win_d   = '0;
               state_d = (GUARD_CYCLES == 0) ? StRx : StGuard;
            end
         end
         StGuard: begin
            if (win_q == GuardLast) begin
               win_d   = '0;
               state_d = StRx;
            end
         end
         StRx: begin
            if (win_q == RxLast) begin
               win_d = '0;
`ifdef RADAR_PULSE_SEQ_DUMP_EN
               state_d = StDump;
`else
               state_d = StWait;
`endif
            end
         end
`ifdef RADAR_PULSE_SEQ_DUMP_EN
         StDump: begin
            win_d = '0;
            // After an overrun the frame is already over, so skip WAIT entirely.
            if (dump_ack) begin
               if (pri_last) state_d = run ? StTx : StIdle;
               else          state_d = StWait;
            end
         end
`endif
         StWait: begin
            win_d = '0;
            if (pri_last) state_d = run ? StTx : StIdle;
         end
         default: begin
            win_d   = '0;
            state_d = StIdle;
         end
      endcase

      frame_start   = (state_d == StTx) && (state_q != StTx);
      chirp_start_d = frame_start;
      chirp_en_d    = (state_d == StTx);
      dac_pd_d      = (state_d == StIdle);
      // First cycle after TX: first GUARD cycle, or first RX cycle when there is no guard.
      fir_clear_d   = (state_q == StTx) && (state_d != StTx);
      fir_en_d      = (state_d == StRx);
      busy_d        = (state_d != StIdle);
      pulse_cnt_d   = frame_start ? pulse_cnt_q + 1'b1 : pulse_cnt_q;
   end

   // State, window counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         win_q         <= '0;
         pulse_cnt_q   <= '0;
         chirp_start_q <= 1'b0;
         chirp_en_q    <= 1'b0;
         dac_pd_q      <= 1'b1;
         fir_clear_q   <= 1'b0;
         fir_en_q      <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         win_q         <= win_d;
         pulse_cnt_q   <= pulse_cnt_d;
         chirp_start_q <= chirp_start_d;
         chirp_en_q    <= chirp_en_d;
         dac_pd_q      <= dac_pd_d;
         fir_clear_q   <= fir_clear_d;
         fir_en_q      <= fir_en_d;
         busy_q        <= busy_d;
      end
   end

`ifdef RADAR_PULSE_SEQ_DUMP_EN
   localparam logic [CNT_W-1:0] PriPenult = CNT_W'(PRI_CYCLES - 2);

   logic dump_req_q, dump_req_d;
   logic overrun_q, overrun_d;

   // Overrun arms when DUMP is still active as the frame counter reaches its last cycle.
   always_comb begin
      dump_req_d = (state_d == StDump);
      overrun_d  = overrun_q | ((state_d == StDump) && (pri_cnt >= PriPenult));
   end

   // Dump handshake and sticky overrun registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dump_req_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         dump_req_q <= dump_req_d;
         overrun_q  <= overrun_d;
      end
   end

   assign dump_req = dump_req_q;
   assign overrun  = overrun_q;
`else
   logic unused_sig;
   assign unused_sig = dump_ack ^ (^pri_cnt);
   assign dump_req   = 1'b0;
   assign overrun    = 1'b0;
`endif

   assign chirp_start = chirp_start_q;
   assign chirp_en    = chirp_en_q;
   assign dac_pd      = dac_pd_q;
   assign fir_clear   = fir_clear_q;
   assign fir_en      = fir_en_q;
   assign busy        = busy_q;
   assign pulse_cnt   = pulse_cnt_q;

endmodule
